ser_par_conv_param: RTL

//  Parametrised serial-to-parallel converter with a decoupled output stage.

---
 rtl/ser_par_conv_param_if.sv | 37 +++
 rtl/ser_par_conv_param.sv | 117 +++++++++++
 2 files changed

// File: rtl/ser_par_conv_param_if.sv
// Word-side handshake bundle for ser_par_conv_param.
// The master side drives the serial beats, ack and clr_ovr.
// The slave side (the converter) returns the assembled word and status.
// The PARITY_CHECK_EN macro adds the parity_err signal.
interface ser_par_conv_param_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 1
);
    logic             En;
    logic [LANES-1:0] Data_in;
    logic             msb_first;
    logic             ack;
    logic             clr_ovr;
    logic [WIDTH-1:0] Data_out;
    logic             write;
    logic             busy;
    logic             overrun;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    modport master (
        output En, Data_in, msb_first, ack, clr_ovr,
`ifdef PARITY_CHECK_EN
        input  parity_err,
`endif
        input  Data_out, write, busy, overrun
    );

    modport slave (
        input  En, Data_in, msb_first, ack, clr_ovr,
`ifdef PARITY_CHECK_EN
        output parity_err,
`endif
        output Data_out, write, busy, overrun
    );
endinterface

// File: rtl/ser_par_conv_param.sv
// Serial-to-parallel converter with a one-entry output holding register.
// Each enabled clock accepts LANES bits, and WIDTH/LANES beats form one word.
// A finished word is offered through a write/ack handshake.
// Shifting of the next word goes on while the previous word waits to be taken.
// Optional feature macro: PARITY_CHECK_EN.
// When it is defined, an extra even-parity beat follows each word and parity_err is reported.
module ser_par_conv_param #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ser_par_conv_param_if.slave  bus
);
    localparam int unsigned BEATS = WIDTH / LANES;
`ifdef PARITY_CHECK_EN
    localparam int unsigned NBEATS = BEATS + 1;
`else
    localparam int unsigned NBEATS = BEATS;
`endif
    localparam int unsigned CNT_W = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    typedef enum logic {StIdle, StShift} asm_state_e;
    typedef enum logic {StEmpty, StFull} out_state_e;

    asm_state_e       r_asm_state;
    out_state_e       r_out_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic             r_msb;
    logic [WIDTH-1:0] r_data;
    logic             r_ovr;
`ifdef PARITY_CHECK_EN
    logic             r_perr;
`endif

    logic             w_msb;
    logic [WIDTH-1:0] w_sr_shift;
    logic             w_done;
    logic             w_data_beat;
    logic [WIDTH-1:0] w_word;
    logic             w_par;

    // msb_first is taken live only on a word's first beat, then held from the latch.
    assign w_msb      = (r_asm_state == StIdle) ? bus.msb_first : r_msb;
    assign w_sr_shift = w_msb ? {r_sr[WIDTH-LANES-1:0], bus.Data_in}
                              : {bus.Data_in, r_sr[WIDTH-1:LANES]};
    assign w_done     = bus.En && (r_cnt == LAST_CNT);

`ifdef PARITY_CHECK_EN
    // The final beat carries parity in lane 0, so the word itself is already in r_sr.
    assign w_data_beat = bus.En && (r_cnt != LAST_CNT);
    assign w_word      = r_sr;
    assign w_par       = ^{r_sr, bus.Data_in[0]};
`else
    assign w_data_beat = bus.En;
    assign w_word      = w_sr_shift;
    assign w_par       = 1'b0;
`endif

    // Assembler and output-stage state; overrun is sticky and set wins over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_asm_state <= StIdle;
            r_out_state <= StEmpty;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_msb       <= 1'b0;
            r_data      <= '0;
            r_ovr       <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_perr      <= 1'b0;
`endif
        end else begin
            if (bus.En) begin
                if (r_asm_state == StIdle) begin
                    r_msb <= bus.msb_first;
                end
                r_cnt       <= w_done ? '0 : r_cnt + CNT_W'(1);
                r_asm_state <= w_done ? StIdle : StShift;
            end
            if (w_data_beat) begin
                r_sr <= w_sr_shift;
            end

            if (w_done && ((r_out_state == StEmpty) || bus.ack)) begin
                r_data      <= w_word;
                r_out_state <= StFull;
`ifdef PARITY_CHECK_EN
                r_perr      <= w_par;
`endif
            end else if ((r_out_state == StFull) && bus.ack) begin
                r_out_state <= StEmpty;
            end

            if (w_done && (r_out_state == StFull) && !bus.ack) begin
                r_ovr <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifndef PARITY_CHECK_EN
    logic w_unused;
    assign w_unused = w_par;
`endif

    assign bus.Data_out   = r_data;
    assign bus.write      = (r_out_state == StFull);
    assign bus.busy       = (r_cnt != '0);
    assign bus.overrun    = r_ovr;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = r_perr;
`endif
endmodule
